branch_redirect: RTL and testbench

//  Decode-side partner of the fetch stage. Inspects the older word of the 32-bit fetch window,

---
 rtl/branch_redirect.sv | 143 ++++++++++++++
 tb/tb_branch_redirect.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect.sv
// Decode-side fetch redirect controller for AAP branch/jump instructions.
// Optional taken-redirect statistics counter enabled by BRANCH_REDIRECT_STATS_EN.
module branch_redirect #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned TIMEOUT      = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] fetchoutput,
  input  logic [19:0] instruction_rd1,
  input  logic [19:0] previous_programcounter,
  output logic [2:0]  pcjumpenable,
  output logic [8:0]  pcchange,
  output logic [5:0]  pclocation,
  output logic        flush,
  output logic        link_valid,
  output logic [19:0] link_address,
  output logic        redirect_abort,
  output logic [15:0] redirect_count
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REDIRECT = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  timer;
  logic [3:0]  drain_cnt;
  logic [19:0] target;
  logic [19:0] link_base;

  logic [15:0] word;
  logic [2:0]  dec_code;
  logic        dec_rel;
  logic [19:0] rel_target;
  logic [19:0] abs_target;
  logic        run;
  logic        match;
  logic        unused_younger;

  assign word           = fetchoutput[31:16];
  assign unused_younger = ^fetchoutput[15:0];
  assign rel_target     = previous_programcounter + {11'b0, word[8:0]} - 20'd1;
  assign abs_target     = {14'b0, word[5:0]};
  assign run            = (stop == 1'b1);
  assign match          = (state == S_REDIRECT) && (instruction_rd1 == target);

  always_comb begin
    dec_code = 3'd0;
    if (!word[15] && word[14:13] == 2'b10) begin
      case (word[12:9])
        4'b0000: dec_code = 3'd1;
        4'b0100: dec_code = 3'd4;
        4'b0010: dec_code = 3'd2;
        4'b0011: dec_code = 3'd3;
        default: dec_code = 3'd0;
      endcase
    end
    dec_rel = (dec_code == 3'd1) || (dec_code == 3'd4);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      timer          <= '0;
      drain_cnt      <= '0;
      target         <= '0;
      link_base      <= '0;
      pcjumpenable   <= '0;
      pcchange       <= '0;
      pclocation     <= '0;
      flush          <= 1'b0;
      link_valid     <= 1'b0;
      link_address   <= '0;
      redirect_abort <= 1'b0;
    end else if (run) begin
      link_valid     <= 1'b0;
      redirect_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dec_code != 3'd0) begin
            state        <= S_REDIRECT;
            pcjumpenable <= dec_code;
            pcchange     <= dec_rel ? word[8:0] : '0;
            pclocation   <= dec_rel ? '0 : word[5:0];
            target       <= dec_rel ? rel_target : abs_target;
            link_base    <= previous_programcounter + 20'd1;
            timer        <= '0;
            flush        <= 1'b1;
          end
        end
        S_REDIRECT: begin
          if (match) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_LAST;
          end else if (timer == TIMER_LAST) begin
            state          <= S_IDLE;
            pcjumpenable   <= '0;
            pcchange       <= '0;
            pclocation     <= '0;
            flush          <= 1'b0;
            redirect_abort <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state        <= S_IDLE;
            pcjumpenable <= '0;
            pcchange     <= '0;
            pclocation   <= '0;
            flush        <= 1'b0;
            if (pcjumpenable == 3'd3 || pcjumpenable == 3'd4) begin
              link_valid   <= 1'b1;
              link_address <= link_base;
            end
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  // Counts only completed redirects (REDIRECT->DRAIN); aborts never reach this path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      redirect_count <= '0;
    else if (run && match && redirect_count != 16'hFFFF)
      redirect_count <= redirect_count + 16'd1;
  end
`else
  assign redirect_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Self-checking bench for branch_redirect: directed scenarios plus randomized
// stimulus compared every cycle against a transaction-level reference model.
module tb_branch_redirect;

  localparam int DRAIN   = 2;
  localparam int TMO     = 31;
`ifdef BRANCH_REDIRECT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        stop;
  logic [31:0] fetchoutput;
  logic [19:0] instruction_rd1;
  logic [19:0] previous_programcounter;
  logic [2:0]  pcjumpenable;
  logic [8:0]  pcchange;
  logic [5:0]  pclocation;
  logic        flush;
  logic        link_valid;
  logic [19:0] link_address;
  logic        redirect_abort;
  logic [15:0] redirect_count;

  int errors = 0;
  int checks = 0;

  branch_redirect #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .stop(stop), .fetchoutput(fetchoutput),
    .instruction_rd1(instruction_rd1), .previous_programcounter(previous_programcounter),
    .pcjumpenable(pcjumpenable), .pcchange(pcchange), .pclocation(pclocation),
    .flush(flush), .link_valid(link_valid), .link_address(link_address),
    .redirect_abort(redirect_abort), .redirect_count(redirect_count)
  );

  always #5 clock = ~clock;

  // Reference model: one outstanding request described by its phase counters.
  bit          m_busy, m_draining;
  int          m_waited, m_drain_left;
  logic [2:0]  m_code;
  logic [8:0]  m_pcchange;
  logic [5:0]  m_pclocation;
  logic        m_flush, m_abort, m_link_valid;
  logic [19:0] m_target, m_return, m_link_address;
  int          m_stats;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] decode(input logic [15:0] w);
    if (w[15:13] != 3'b010) return 3'd0;
    case (w[12:9])
      4'h0: return 3'd1;
      4'h4: return 3'd4;
      4'h2: return 3'd2;
      4'h3: return 3'd3;
      default: return 3'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 0; m_draining = 0; m_waited = 0; m_drain_left = 0;
    m_code = 0; m_pcchange = 0; m_pclocation = 0; m_flush = 0;
    m_abort = 0; m_link_valid = 0; m_target = 0; m_return = 0;
    m_link_address = 0; m_stats = 0;
  endtask

  task automatic model_idle_outputs();
    m_busy = 0; m_draining = 0; m_code = 0; m_pcchange = 0; m_pclocation = 0; m_flush = 0;
  endtask

  task automatic model_step(input logic st, input logic [31:0] fo, input logic [19:0] rd1,
                            input logic [19:0] prev);
    logic [15:0] w;
    logic [2:0]  c;
    int          sum;
    if (st !== 1'b1) return;
    m_abort = 0;
    m_link_valid = 0;
    w = fo[31:16];
    if (!m_busy) begin
      c = decode(w);
      if (c != 0) begin
        m_busy = 1; m_draining = 0; m_waited = 0;
        m_code = c; m_flush = 1;
        m_return = 20'((int'(prev) + 1) % (1 << 20));
        if (c == 1 || c == 4) begin
          sum = (int'(prev) + int'(w[8:0]) - 1 + (1 << 20)) % (1 << 20);
          m_target = 20'(sum);
          m_pcchange = w[8:0];
          m_pclocation = 0;
        end else begin
          m_target = 20'(int'(w[5:0]));
          m_pcchange = 0;
          m_pclocation = w[5:0];
        end
      end
    end else if (!m_draining) begin
      if (rd1 == m_target) begin
        m_draining = 1;
        m_drain_left = DRAIN;
        if (STATS != 0 && m_stats < 65535) m_stats++;
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_abort = 1;
          model_idle_outputs();
        end
      end
    end else begin
      m_drain_left--;
      if (m_drain_left == 0) begin
        if (m_code == 3 || m_code == 4) begin
          m_link_valid = 1;
          m_link_address = m_return;
        end
        model_idle_outputs();
      end
    end
  endtask

  task automatic compare_all();
    check("pcjumpenable", pcjumpenable, m_code);
    check("pcchange", pcchange, m_pcchange);
    check("pclocation", pclocation, m_pclocation);
    check("flush", flush, m_flush);
    check("link_valid", link_valid, m_link_valid);
    check("link_address", link_address, m_link_address);
    check("redirect_abort", redirect_abort, m_abort);
    check("redirect_count", redirect_count, m_stats);
  endtask

  task automatic drive(input logic st, input logic [15:0] w, input logic [19:0] rd1,
                       input logic [19:0] prev);
    stop = st;
    fetchoutput = {w, 16'($urandom)};
    instruction_rd1 = rd1;
    previous_programcounter = prev;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step(stop, fetchoutput, instruction_rd1, previous_programcounter);
    #1 compare_all();
  endtask

  task automatic random_inputs();
    logic [15:0] w;
    logic [3:0]  ops [6];
    logic [19:0] rd1, prev;
    ops = '{4'h0, 4'h4, 4'h2, 4'h3, 4'h1, 4'hF};
    case ($urandom_range(0, 5))
      0: w = 16'h0001;
      1: w = 16'h0000;
      2: w = 16'($urandom);
      default: w = {3'b010, ops[$urandom_range(0, 5)], 9'($urandom)};
    endcase
    prev = ($urandom_range(0, 3) == 0) ? 20'hFFFFF - 20'($urandom_range(0, 3)) : 20'($urandom);
    rd1 = (m_busy && $urandom_range(0, 3) == 0) ? m_target : 20'($urandom);
    drive(($urandom_range(0, 9) != 0), w, rd1, prev);
  endtask

  initial begin
    model_reset();
    reset = 1'b0;
    drive(1'b1, 16'h0001, 20'h0, 20'h0);
    repeat (2) @(posedge clock);
    #1 compare_all();
    #2 reset = 1'b1;

    // 1: reset mid-REDIRECT of a code 2 jump
    drive(1'b1, 16'h4407, 20'h00000, 20'h00020);
    cycle();
    check("t1_code", pcjumpenable, 3'd2);
    drive(1'b1, 16'h0001, 20'h00000, 20'h00020);
    cycle();
    #2 reset = 1'b0;
    model_reset();
    #1 compare_all();
    check("t1_flush_rst", flush, 1'b0);
    #1 reset = 1'b1;
    cycle();
    check("t1_idle_code", pcjumpenable, 3'd0);

    // 2: BRA +5 from 0x00010, target 0x00014
    drive(1'b1, 16'h4005, 20'h00000, 20'h00010);
    cycle();
    check("t2_code", pcjumpenable, 3'd1);
    check("t2_pcchange", pcchange, 9'h005);
    drive(1'b1, 16'h0001, 20'h00014, 20'h00011);
    cycle();
    check("t2_flush_d1", flush, 1'b1);
    cycle();
    check("t2_flush_d2", flush, 1'b1);
    cycle();
    check("t2_code_end", pcjumpenable, 3'd0);
    check("t2_flush_end", flush, 1'b0);

    // 3: JAL 0x29 from 0x00100, link 0x00101
    drive(1'b1, 16'h4629, 20'h00000, 20'h00100);
    cycle();
    check("t3_code", pcjumpenable, 3'd3);
    check("t3_pclocation", pclocation, 6'h29);
    drive(1'b1, 16'h0001, 20'h00029, 20'h00101);
    repeat (3) cycle();
    check("t3_link_valid", link_valid, 1'b1);
    check("t3_link_address", link_address, 20'h00101);
    drive(1'b1, 16'h0001, 20'h0002A, 20'h00029);
    cycle();
    check("t3_link_pulse_end", link_valid, 1'b0);

    // 4: BRA whose target never arrives
    drive(1'b1, 16'h4005, 20'h00000, 20'h00010);
    cycle();
    drive(1'b1, 16'h0001, 20'h00000, 20'h00010);
    repeat (TMO - 1) cycle();
    check("t4_code_before", pcjumpenable, 3'd1);
    check("t4_abort_before", redirect_abort, 1'b0);
    cycle();
    check("t4_abort", redirect_abort, 1'b1);
    check("t4_code_after", pcjumpenable, 3'd0);
    check("t4_no_link", link_valid, 1'b0);
    cycle();
    check("t4_abort_pulse_end", redirect_abort, 1'b0);

    // 5: relative target wraps around the 20-bit PC space
    drive(1'b1, 16'h4003, 20'h00000, 20'hFFFFF);
    cycle();
    check("t5_target_model", m_target, 20'h00001);
    drive(1'b1, 16'h0001, 20'h00001, 20'h00000);
    cycle();
    check("t5_flush", flush, 1'b1);
    repeat (2) cycle();
    check("t5_code_end", pcjumpenable, 3'd0);
    check("t5_stats", redirect_count, (STATS != 0) ? 16'd3 : 16'd0);

    // 6: stall during DRAIN
    drive(1'b1, 16'h4002, 20'h00000, 20'h00200);
    cycle();
    drive(1'b1, 16'h0001, 20'h00201, 20'h00201);
    cycle();
    drive(1'b0, 16'h4005, 20'h00201, 20'h00201);
    repeat (5) begin
      cycle();
      check("t6_frozen_code", pcjumpenable, 3'd1);
    end
    drive(1'b1, 16'h0001, 20'h00201, 20'h00201);
    repeat (2) cycle();
    check("t6_code_end", pcjumpenable, 3'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
